// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator datapath.
// Opcode encoding, FSM state encoding, and the ALU subset boundary.
package acc_pkg;

    // Opcodes as presented on the op bus
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_LOADB = 3'd5,
        OP_MUL   = 3'd6,
        OP_NOP   = 3'd7
    } op_e;

    // Sequencer state: single-cycle ops run from IDLE, MUL is iterative
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Ops handled in one cycle by the ALU (ADD..LOADB)
    function automatic logic is_alu_op(input op_e op);
        return (op != OP_MUL) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/acc_if.sv
// Operand/command bus and status outputs of the accumulator datapath.
// master drives commands and observes status; slave is the datapath.
interface acc_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] abus;
    logic             sel_b;
    logic             load_ac;
    logic [2:0]       op;
    logic [WIDTH-1:0] outbus;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output abus, sel_b, load_ac, op,
        input  outbus, carry, zero, busy, done
    );

    modport slave (
        input  abus, sel_b, load_ac, op,
        output outbus, carry, zero, busy, done
    );
endinterface

// File: rtl/acc_alu.sv
// Combinational ALU for the single-cycle ops ADD/SUB/AND/OR/XOR/LOADB.
// Returns the WIDTH-bit result and carry (ADD carry-out, SUB borrow).
module acc_alu
    import acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Result select; the extra top bit of sum/diff is carry-out/borrow
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        res   = a;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_LOADB: res = b;
            default: begin
                res   = a;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acc_datapath.sv
// Accumulator datapath: single-cycle ALU ops plus a WIDTH-cycle
// shift-and-add multiplier sequenced by a two-state FSM.
// Optional scan chain (AC[0]..AC[WIDTH-1], carry, zero) when the
// ACC_SCAN_EN macro is defined; default build has no scan ports.
module acc_datapath
    import acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    acc_if.slave bus
`ifdef ACC_SCAN_EN
    ,
    input  logic scan_en,
    input  logic scan_in,
    output logic scan_out
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Control state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    // Multiplier working registers
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] part_q, part_d;

    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH-1:0] part_sum;
    op_e              op_in;
    logic             mul_last;
    logic             scan_shift;

    assign op_in    = op_e'(bus.op);
    assign mul_last = (cnt_q == CNT_LAST);

`ifdef ACC_SCAN_EN
    assign scan_shift = scan_en;
    assign scan_out   = zero_q;
`else
    assign scan_shift = 1'b0;
`endif

    acc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a     (ac_q),
        .b     (b_op),
        .op    (op_in),
        .res   (alu_res),
        .carry (alu_carry)
    );

    // Operand B mux and the partial-product adder for the current MUL step
    always_comb begin
        b_op     = bus.sel_b ? bus.abus : ac_q;
        part_sum = part_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Control/status registers; reset aborts any in-flight MUL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ac_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ac_q    <= ac_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    // Multiplier operands carry no meaning outside ST_MUL, so no reset
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        part_q   <= part_d;
    end

    // Next state: MUL issued from IDLE runs until the counter's last step
    always_comb begin
        state_d = state_q;
        if (!scan_shift) begin
            case (state_q)
                ST_IDLE: if (bus.load_ac && (op_in == OP_MUL)) state_d = ST_MUL;
                ST_MUL:  if (mul_last) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Next register values: ALU writes, MUL capture/step/final write, scan shift
    always_comb begin
        ac_d     = ac_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        part_d   = part_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.load_ac) begin
                    if (is_alu_op(op_in)) begin
                        ac_d    = alu_res;
                        carry_d = alu_carry;
                        zero_d  = (alu_res == '0);
                    end else if (op_in == OP_MUL) begin
                        mcand_d  = ac_q;
                        mplier_d = b_op;
                        part_d   = '0;
                        cnt_d    = '0;
                    end
                end
            end
            ST_MUL: begin
                // Inputs are ignored here; only captured operands matter
                part_d   = part_sum;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (mul_last) begin
                    ac_d    = part_sum;
                    carry_d = 1'b0;
                    zero_d  = (part_sum == '0);
                    done_d  = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase

`ifdef ACC_SCAN_EN
        // Scan shift overrides everything and freezes the sequencer
        if (scan_en) begin
            ac_d     = {ac_q[WIDTH-2:0], scan_in};
            carry_d  = ac_q[WIDTH-1];
            zero_d   = carry_q;
            done_d   = 1'b0;
            cnt_d    = cnt_q;
            mcand_d  = mcand_q;
            mplier_d = mplier_q;
            part_d   = part_q;
        end
`endif
    end

    // Status outputs come straight from registered state
    always_comb begin
        bus.outbus = ac_q;
        bus.carry  = carry_q;
        bus.zero   = zero_q;
        bus.busy   = (state_q == ST_MUL);
        bus.done   = done_q;
    end

endmodule

// File: tb/tb_acc_datapath.sv
// Self-checking bench for acc_datapath at WIDTH=4 and WIDTH=8.
// Directed scenarios plus randomized ops against an arithmetic model.
module tb_acc_datapath;
    import acc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    acc_if #(.WIDTH(4)) if4 ();
    acc_if #(.WIDTH(8)) if8 ();

`ifdef ACC_SCAN_EN
    logic scan_en4, scan_in4, scan_out4;
    logic scan_en8, scan_in8, scan_out8;
`endif

    acc_datapath #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
`ifdef ACC_SCAN_EN
        ,
        .scan_en  (scan_en4),
        .scan_in  (scan_in4),
        .scan_out (scan_out4)
`endif
    );

    acc_datapath #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
`ifdef ACC_SCAN_EN
        ,
        .scan_en  (scan_en8),
        .scan_in  (scan_in8),
        .scan_out (scan_out8)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: AC value and flags, index 0 = WIDTH 4, 1 = WIDTH 8
    longint m_ac [2];
    bit     m_c  [2];
    bit     m_z  [2];

    function automatic int widx(input int w);
        return (w == 4) ? 0 : 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ac[i] = 0;
            m_c[i]  = 1'b0;
            m_z[i]  = 1'b1;
        end
    endfunction

    // One issued operation (load_ac=1) in plain arithmetic
    function automatic void model_op(input int w, input int op, input bit sel, input longint ab);
        int     k    = widx(w);
        longint mask = (longint'(1) << w) - 1;
        longint a    = m_ac[k];
        longint b    = sel ? (ab & mask) : a;
        longint r;
        if (op == 7) return;
        case (op)
            0: begin r = a + b; m_c[k] = (r > mask); end
            1: begin r = a - b; m_c[k] = (a < b); end
            2: begin r = a & b; m_c[k] = 1'b0; end
            3: begin r = a | b; m_c[k] = 1'b0; end
            4: begin r = a ^ b; m_c[k] = 1'b0; end
            5: begin r = b;     m_c[k] = 1'b0; end
            default: begin r = a * b; m_c[k] = 1'b0; end
        endcase
        m_ac[k] = r & mask;
        m_z[k]  = (m_ac[k] == 0);
    endfunction

    task automatic drive(input int w, input bit ld, input int op, input bit sel, input longint ab);
        if (w == 4) begin
            if4.load_ac = ld; if4.op = 3'(op); if4.sel_b = sel; if4.abus = 4'(ab);
        end else begin
            if8.load_ac = ld; if8.op = 3'(op); if8.sel_b = sel; if8.abus = 8'(ab);
        end
    endtask

    task automatic sample(input int w, output longint out, output logic c, output logic z,
                          output logic bsy, output logic dn);
        if (w == 4) begin
            out = longint'(if4.outbus); c = if4.carry; z = if4.zero; bsy = if4.busy; dn = if4.done;
        end else begin
            out = longint'(if8.outbus); c = if8.carry; z = if8.zero; bsy = if8.busy; dn = if8.done;
        end
    endtask

    // Issue a single-cycle op at the current negedge, return at the next negedge
    task automatic op_cycle(input int w, input int op, input bit sel, input longint ab);
        drive(w, 1'b1, op, sel, ab);
        @(negedge clk);
        drive(w, 1'b0, 7, 1'b0, 0);
        model_op(w, op, sel, ab);
    endtask

    // Follow a MUL already issued; returns at the negedge where done is seen
    task automatic wait_done(input int w, input bit garbage, output int bc, output bit seen,
                             output int dn_cnt);
        longint o; logic c, z, bsy, dn;
        bc = 0; seen = 1'b0; dn_cnt = 0;
        for (int i = 0; i < w + 6 && !seen; i++) begin
            @(negedge clk);
            sample(w, o, c, z, bsy, dn);
            if (dn) dn_cnt++;
            if (bsy) begin
                bc++;
                if (garbage)
                    drive(w, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                          1'($urandom_range(0, 1)), longint'($urandom));
                else
                    drive(w, 1'b0, 7, 1'b0, 0);
            end else begin
                drive(w, 1'b0, 7, 1'b0, 0);
                if (dn) seen = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        longint o; logic c, z, bsy, dn;
        rst_n = 1'b0;
        drive(4, 1'b0, 7, 1'b0, 0);
        drive(8, 1'b0, 7, 1'b0, 0);
        repeat (2) @(negedge clk);
        model_reset();
        for (int w = 4; w <= 8; w += 4) begin
            sample(w, o, c, z, bsy, dn);
            n_chk++; if (o !== 0) $display("FAIL reset_ac w%0d: got %0h want 0", w, o); else n_pass++;
            n_chk++; if (c !== 1'b0) $display("FAIL reset_carry w%0d: got %b want 0", w, c); else n_pass++;
            n_chk++; if (z !== 1'b1) $display("FAIL reset_zero w%0d: got %b want 1", w, z); else n_pass++;
            n_chk++; if (bsy !== 1'b0) $display("FAIL reset_busy w%0d: got %b want 0", w, bsy); else n_pass++;
            n_chk++; if (dn !== 1'b0) $display("FAIL reset_done w%0d: got %b want 0", w, dn); else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loadb_add();
        longint o; logic c, z, bsy, dn;
        op_cycle(4, OP_LOADB, 1'b1, 'hF);
        sample(4, o, c, z, bsy, dn);
        n_chk++; if (o !== 'hF) $display("FAIL loadb_ac: got %0h want f", o); else n_pass++;
        n_chk++; if (z !== 1'b0) $display("FAIL loadb_zero: got %b want 0", z); else n_pass++;
        op_cycle(4, OP_ADD, 1'b1, 'h6);
        sample(4, o, c, z, bsy, dn);
        n_chk++; if (o !== 'h5) $display("FAIL add_ac: got %0h want 5", o); else n_pass++;
        n_chk++; if (c !== 1'b1) $display("FAIL add_carry: got %b want 1", c); else n_pass++;
    endtask

    task automatic test_sub_xor();
        longint o; logic c, z, bsy, dn;
        op_cycle(4, OP_LOADB, 1'b1, 'h3);
        op_cycle(4, OP_SUB, 1'b1, 'h5);
        sample(4, o, c, z, bsy, dn);
        n_chk++; if (o !== 'hE) $display("FAIL sub_ac: got %0h want e", o); else n_pass++;
        n_chk++; if (c !== 1'b1) $display("FAIL sub_borrow: got %b want 1", c); else n_pass++;
        op_cycle(4, OP_XOR, 1'b0, 'h9);
        sample(4, o, c, z, bsy, dn);
        n_chk++; if (o !== 0) $display("FAIL xor_ac: got %0h want 0", o); else n_pass++;
        n_chk++; if (z !== 1'b1) $display("FAIL xor_zero: got %b want 1", z); else n_pass++;
        n_chk++; if (c !== 1'b0) $display("FAIL xor_carry: got %b want 0", c); else n_pass++;
    endtask

    task automatic test_mul_basic();
        longint o; logic c, z, bsy, dn;
        int busy_n = 0, done_n = 0, done_at = -1, last_busy = -1;
        op_cycle(8, OP_LOADB, 1'b1, 'h0C);
        drive(8, 1'b1, OP_MUL, 1'b1, 'h0B);
        model_op(8, OP_MUL, 1'b1, 'h0B);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            sample(8, o, c, z, bsy, dn);
            if (bsy) begin busy_n++; last_busy = i; end
            if (dn) begin done_n++; done_at = i; end
            if (i == 2) drive(8, 1'b1, OP_ADD, 1'b1, 'hFF);
            else        drive(8, 1'b0, 7, 1'b0, 0);
        end
        sample(8, o, c, z, bsy, dn);
        n_chk++; if (busy_n != 8) $display("FAIL mul_busy_len: got %0d want 8", busy_n); else n_pass++;
        n_chk++; if (done_n != 1) $display("FAIL mul_done_len: got %0d want 1", done_n); else n_pass++;
        n_chk++; if (done_at != last_busy + 1) $display("FAIL mul_done_pos: got %0d want %0d", done_at, last_busy + 1); else n_pass++;
        n_chk++; if (o !== 'h84) $display("FAIL mul_ac: got %0h want 84", o); else n_pass++;
        n_chk++; if (o !== m_ac[1]) $display("FAIL mul_model: got %0h want %0h", o, m_ac[1]); else n_pass++;
        n_chk++; if (z !== 1'b0) $display("FAIL mul_zero: got %b want 0", z); else n_pass++;
    endtask

    task automatic test_mul_trunc();
        longint o; logic c, z, bsy, dn;
        int bc, dc; bit seen;
        op_cycle(8, OP_LOADB, 1'b1, 'h20);
        drive(8, 1'b1, OP_MUL, 1'b1, 'h10);
        model_op(8, OP_MUL, 1'b1, 'h10);
        wait_done(8, 1'b0, bc, seen, dc);
        n_chk++; if (!seen) $display("FAIL trunc_done_timeout: got no done want done"); else n_pass++;
        @(negedge clk);
        sample(8, o, c, z, bsy, dn);
        n_chk++; if (o !== 0) $display("FAIL trunc_ac: got %0h want 0", o); else n_pass++;
        n_chk++; if (z !== 1'b1) $display("FAIL trunc_zero: got %b want 1", z); else n_pass++;
        n_chk++; if (c !== 1'b0) $display("FAIL trunc_carry: got %b want 0", c); else n_pass++;
    endtask

    task automatic test_mul_reset();
        longint o; logic c, z, bsy, dn;
        int stray = 0;
        op_cycle(8, OP_LOADB, 1'b1, 'h37);
        drive(8, 1'b1, OP_MUL, 1'b1, 'h05);
        @(negedge clk);
        drive(8, 1'b0, 7, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        sample(8, o, c, z, bsy, dn);
        n_chk++; if (bsy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", bsy); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sample(8, o, c, z, bsy, dn);
        n_chk++; if (o !== 0) $display("FAIL rst_mul_ac: got %0h want 0", o); else n_pass++;
        n_chk++; if (bsy !== 1'b0) $display("FAIL rst_mul_busy: got %b want 0", bsy); else n_pass++;
        n_chk++; if (z !== 1'b1) $display("FAIL rst_mul_zero: got %b want 1", z); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sample(8, o, c, z, bsy, dn);
            if (dn || bsy) stray++;
        end
        n_chk++; if (stray != 0) $display("FAIL rst_mul_no_done: got %0d busy/done cycles want 0", stray); else n_pass++;
        n_chk++; if (o !== 0) $display("FAIL rst_mul_ac_after: got %0h want 0", o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        longint o; logic c, z, bsy, dn;
        int bc, dc; bit seen;
        op_cycle(4, OP_LOADB, 1'b1, 'h3);
        drive(4, 1'b1, OP_MUL, 1'b1, 'h5);
        model_op(4, OP_MUL, 1'b1, 'h5);
        wait_done(4, 1'b0, bc, seen, dc);
        n_chk++; if (!seen) $display("FAIL b2b_done_timeout: got no done want done"); else n_pass++;
        sample(4, o, c, z, bsy, dn);
        n_chk++; if (o !== 'hF) $display("FAIL b2b_mul_ac: got %0h want f", o); else n_pass++;
        op_cycle(4, OP_ADD, 1'b1, 'h1);
        sample(4, o, c, z, bsy, dn);
        n_chk++; if (o !== 0 || c !== 1'b1 || z !== 1'b1)
            $display("FAIL b2b_add: got ac=%0h c=%b z=%b want ac=0 c=1 z=1", o, c, z);
        else n_pass++;
    endtask

    task automatic test_random(input int w, input int n);
        longint o; logic c, z, bsy, dn;
        int bc, dc; bit seen;
        int op; bit ld, sel; longint ab;
        int k = widx(w);
        for (int it = 0; it < n; it++) begin
            op  = $urandom_range(0, 7);
            ld  = ($urandom_range(0, 3) != 0);
            sel = 1'($urandom_range(0, 1));
            ab  = longint'($urandom);
            drive(w, ld, op, sel, ab);
            if (ld && op == OP_MUL) begin
                model_op(w, op, sel, ab);
                wait_done(w, 1'b1, bc, seen, dc);
                n_chk++; if (!seen || bc != w || dc != 1)
                    $display("FAIL rand_mul_seq w%0d it%0d: got busy=%0d done=%0d seen=%b want busy=%0d done=1", w, it, bc, dc, seen, w);
                else n_pass++;
            end else begin
                @(negedge clk);
                drive(w, 1'b0, 7, 1'b0, 0);
                if (ld) model_op(w, op, sel, ab);
            end
            sample(w, o, c, z, bsy, dn);
            n_chk++; if (o !== m_ac[k] || c !== m_c[k] || z !== m_z[k] || bsy !== 1'b0)
                $display("FAIL rand_state w%0d it%0d op%0d: got ac=%0h c=%b z=%b busy=%b want ac=%0h c=%b z=%b busy=0",
                         w, it, op, o, c, z, bsy, m_ac[k], m_c[k], m_z[k]);
            else n_pass++;
        end
    endtask

`ifdef ACC_SCAN_EN
    task automatic test_scan();
        longint o; logic c, z, bsy, dn;
        logic [5:0] pat   = 6'b101101;
        logic [5:0] prior = 6'b001010;
        logic [5:0] got   = '0;
        op_cycle(4, OP_LOADB, 1'b1, 'hA);
        for (int i = 0; i < 6; i++) begin
            scan_en4 = 1'b1;
            scan_in4 = pat[5 - i];
            got = {got[4:0], scan_out4};
            @(negedge clk);
        end
        scan_en4 = 1'b0;
        sample(4, o, c, z, bsy, dn);
        n_chk++; if ({z, c, o[3:0]} !== pat) $display("FAIL scan_load: got %b want %b", {z, c, o[3:0]}, pat); else n_pass++;
        n_chk++; if (got !== prior) $display("FAIL scan_out: got %b want %b", got, prior); else n_pass++;
        m_ac[0] = 'hD; m_c[0] = 1'b0; m_z[0] = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        drive(4, 1'b0, 7, 1'b0, 0);
        drive(8, 1'b0, 7, 1'b0, 0);
`ifdef ACC_SCAN_EN
        scan_en4 = 1'b0; scan_in4 = 1'b0;
        scan_en8 = 1'b0; scan_in8 = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_loadb_add();
        test_sub_xor();
        test_mul_basic();
        test_mul_trunc();
        test_mul_reset();
        test_back_to_back();
`ifdef ACC_SCAN_EN
        test_scan();
`endif
        test_random(4, 150);
        test_random(8, 150);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
